// File: rtl/fpu_pkg.sv
// Shared FP32 field layout and sequencer state encoding.
// Flush-to-zero helper is compiled only when OPERAND_SEQ_FTZ_EN is defined.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;

    localparam int SIGN_POS = W - 1;
    localparam int EXP_MSB  = W - 2;
    localparam int EXP_LSB  = MAN_W;
    localparam int MAN_MSB  = MAN_W - 1;
    localparam int PAIR_W   = 2 * W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } seq_state_t;

`ifdef OPERAND_SEQ_FTZ_EN
    // Denormals (exponent field zero) collapse to a signed zero.
    function automatic logic [W-1:0] ftz(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        if (x[EXP_MSB:EXP_LSB] == '0)
            r[MAN_MSB:0] = '0;
        return r;
    endfunction
`endif

endpackage

// File: rtl/operand_fifo.sv
// Synchronous operand-pair FIFO; pointers wrap modulo DEPTH (power of two).
// Push is ignored when full and pop when empty, so callers may assert them freely.
module operand_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [PAIR_W-1:0]          push_data,
    input  logic                       pop,
    output logic [PAIR_W-1:0]          pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PAIR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && (count < CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Buffers FP32 operand pairs and presents A then B to an adder over stb/ack.
// Optional flush-to-zero at pop: define OPERAND_SEQ_FTZ_EN.
module operand_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           output_a,
    output logic                   output_a_stb,
    input  logic                   output_a_ack,
    output logic [W-1:0]           output_b,
    output logic                   output_b_stb,
    input  logic                   output_b_ack,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a transfer happens on an edge where stb and ack are both high;
    // stb and data stay put until then, and only one stb is ever high at once.

    seq_state_t        state;
    seq_state_t        next_state;
    logic              pop;
    logic [PAIR_W-1:0] head;
    logic [W-1:0]      head_a;
    logic [W-1:0]      head_b;

    operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    assign in_ready = (count < CW'(DEPTH));

`ifdef OPERAND_SEQ_FTZ_EN
    assign head_a = ftz(head[PAIR_W-1:W]);
    assign head_b = ftz(head[W-1:0]);
`else
    assign head_a = head[PAIR_W-1:W];
    assign head_b = head[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (output_a_ack)
                    next_state = ST_SEND_B;
            end
            ST_SEND_B: begin
                if (output_b_ack) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        next_state = ST_SEND_A;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        output_a_stb = (state == ST_SEND_A);
        output_b_stb = (state == ST_SEND_B);
    end

    // Holding register doubles as the registered operand outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_a <= '0;
            output_b <= '0;
        end else if (pop) begin
            output_a <= head_a;
            output_b <= head_b;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer (DEPTH=4); each scenario task checks inline.
module tb_operand_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack;
    logic [2:0]  count;

    int checks;
    int failures;
    logic [63:0] exp_q[$];

    operand_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .output_a     (output_a),
        .output_a_stb (output_a_stb),
        .output_a_ack (output_a_ack),
        .output_b     (output_b),
        .output_b_stb (output_b_stb),
        .output_b_ack (output_b_ack),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        exp_q.push_back({a, b});
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0) begin
            failures++; $display("FAIL reset_stb got a=%b b=%b exp=0,0", output_a_stb, output_b_stb);
        end
        checks++;
        if (output_a !== 32'h0 || output_b !== 32'h0) begin
            failures++; $display("FAIL reset_data got a=%h b=%h exp=0,0", output_a, output_b);
        end
    endtask

    task automatic test_basic();
        output_a_ack = 1'b1;
        output_b_ack = 1'b1;
        push_one(32'h3F800000, 32'h40000000);
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (count !== 3'd1 || output_a_stb !== 1'b0) begin
            failures++; $display("FAIL basic_after_push got count=%0d a_stb=%b exp=1,0", count, output_a_stb);
        end
        tick();
        checks++;
        if (output_a_stb !== 1'b1 || output_a !== 32'h3F800000 || output_b_stb !== 1'b0) begin
            failures++; $display("FAIL basic_send_a got stb=%b a=%h bstb=%b exp=1,3f800000,0", output_a_stb, output_a, output_b_stb);
        end
        tick();
        checks++;
        if (output_b_stb !== 1'b1 || output_b !== 32'h40000000 || output_a_stb !== 1'b0) begin
            failures++; $display("FAIL basic_send_b got stb=%b b=%h astb=%b exp=1,40000000,0", output_b_stb, output_b, output_a_stb);
        end
        tick();
        checks++;
        if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL basic_idle got a=%b b=%b count=%0d exp=0,0,0", output_a_stb, output_b_stb, count);
        end
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
    endtask

    task automatic drain(input int n);
        int got;
        got = 0;
        output_a_ack = 1'b1;
        output_b_ack = 1'b1;
        for (int cyc = 0; cyc < 4 * n + 8 && got < n; cyc++) begin
            if (output_a_stb && output_b_stb) begin
                checks++; failures++; $display("FAIL drain_both_stb got=1,1 exp=exclusive");
            end
            if (output_a_stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL drain_a_extra got=%h exp=none", output_a);
                end else if (output_a !== exp_q[0][63:32]) begin
                    failures++; $display("FAIL drain_a got=%h exp=%h", output_a, exp_q[0][63:32]);
                end
            end
            if (output_b_stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL drain_b_extra got=%h exp=none", output_b);
                end else begin
                    if (output_b !== exp_q[0][31:0]) begin
                        failures++; $display("FAIL drain_b got=%h exp=%h", output_b, exp_q[0][31:0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != n) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", got, n); end
        checks++;
        if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL drain_idle got a=%b b=%b count=%0d exp=0,0,0", output_a_stb, output_b_stb, count);
        end
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_hold();
        push_one(32'h11111111, 32'h22222222);
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (output_a_stb !== 1'b1 || output_a !== 32'h11111111 || output_b_stb !== 1'b0) begin
                failures++; $display("FAIL hold_a cyc=%0d got stb=%b a=%h bstb=%b exp=1,11111111,0", i, output_a_stb, output_a, output_b_stb);
            end
            output_b_ack = (i == 3);
            tick();
        end
        output_b_ack = 1'b0;
        drain(1);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            push_one(32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i));
            if (i == 3) begin
                checks++;
                if (count !== 3'd3 || in_ready !== 1'b1 || output_a_stb !== 1'b1) begin
                    failures++; $display("FAIL fill_four got count=%0d rdy=%b astb=%b exp=3,1,1", count, in_ready, output_a_stb);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL fill_full got count=%0d rdy=%b exp=4,0", count, in_ready);
        end
        drain(5);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            push_one(32'hC0000000 + 32'(i), 32'hD0000000 + 32'(i));
        in_valid = 1'b0;
        output_a_ack = 1'b1;
        tick();
        output_a_ack = 1'b0;
        checks++;
        if (output_b_stb !== 1'b1 || count !== 3'd2) begin
            failures++; $display("FAIL mid_pre got bstb=%b count=%0d exp=1,2", output_b_stb, count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got a=%b b=%b count=%0d rdy=%b exp=0,0,0,1", output_a_stb, output_b_stb, count, in_ready);
        end
        output_a_ack = 1'b1;
        output_b_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0) begin
                failures++; $display("FAIL mid_no_stb cyc=%0d got a=%b b=%b exp=0,0", i, output_a_stb, output_b_stb);
            end
        end
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_ftz();
        logic [31:0] ea;
        logic [31:0] eb;
`ifdef OPERAND_SEQ_FTZ_EN
        ea = 32'h00000000;
        eb = 32'h80000000;
`else
        ea = 32'h00000001;
        eb = 32'h80400000;
`endif
        push_one(32'h00000001, 32'h80400000);
        in_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back({ea, eb});
        tick();
        checks++;
        if (output_a_stb !== 1'b1 || output_a !== ea) begin
            failures++; $display("FAIL ftz_a got stb=%b a=%h exp=1,%h", output_a_stb, output_a, ea);
        end
        drain(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            push_one(32'hE0000000 + 32'(i), 32'hF0000000 + 32'(i));
        in_valid = 1'b0;
        output_a_ack = 1'b1;
        tick();
        output_a_ack = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (output_b_stb !== 1'b1 || count !== 3'd3) begin
            failures++; $display("FAIL b2b_pre got bstb=%b count=%0d exp=1,3", output_b_stb, count);
        end
        output_b_ack = 1'b1;
        push_one(32'hE0000004, 32'hF0000004);
        in_valid = 1'b0;
        output_b_ack = 1'b0;
        checks++;
        if (count !== 3'd3 || output_a_stb !== 1'b1 || output_a !== 32'hE0000001) begin
            failures++; $display("FAIL b2b_same_edge got count=%0d astb=%b a=%h exp=3,1,e0000001", count, output_a_stb, output_a);
        end
        drain(4);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_valid     = 1'b0;
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_fill();
        test_reset_mid();
        test_ftz();
        test_back_to_back();
        test_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
